rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
Parametrised N-requester arbiter, the next generation of the team's 3-input fixed-truth-table arbiter. It supports either fixed-priority or round-robin selection. A winner keeps its grant for as long as its request stays high, up to a bounded hold time. Output is a registered one-hot grant plus an encoded owner ID. It sits in front of any shared resource (bus, memory port, output channel).

Parameters:
N, 4, number of requesters (2..16)
MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin
MAX_HOLD, 4, max consecutive grant cycles while others wait; 0 = unlimited (no preemption)
IDW, $clog2(N), width of grant_id (derived; not overridden)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
request  input  N  per-requester request, level-sensitive, bit i = requester i
grant  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  high when grant != 0
grant_id  output  IDW  binary index of current owner; holds last owner when idle

Behaviour:
- Reset (synchronous): grant=0, grant_valid=0, grant_id=0, hold_cnt=0, rr pointer last=N-1, state=IDLE. Reset overrides all other activity, including mid-grant; the grant drops at the first edge with reset=1.
- States: IDLE (no owner), BUSY (owner = grant_id).
- Latency: a request seen at edge k appears as grant at edge k+1 (registered, 1 cycle). Grant is never asserted on a requester whose request bit was 0 at the deciding edge.
- Winner selection over candidate set C:
  - MODE=0: lowest index in C.
  - MODE=1: first set bit in C scanning from (last+1) mod N upward with wrap. last updates to the winner on each new grant.
- IDLE: if request!=0, C=request; grant winner, hold_cnt=0, go BUSY. Else stay IDLE, outputs 0.
- BUSY, owner request low (release): C=request with owner bit masked.
  - C!=0: grant the new winner at the next edge. There is no idle gap. hold_cnt=0.
  - C=0: grant=0, grant_valid=0, go IDLE; grant_id keeps its value.
- BUSY, owner request high:
  - MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (request with owner masked)!=0: preempt. Grant the winner of the masked set at the next edge, hold_cnt=0.
  - Otherwise keep the owner. hold_cnt increments, saturating at MAX_HOLD-1; it stays at 0 when MAX_HOLD=0.
  - The owner is therefore granted for exactly MAX_HOLD cycles under contention.
- Preemption or handover never produces two grant bits at once and never produces a zero-grant cycle while requests are pending.
- Simultaneous events: a new request arriving at the same edge as owner release joins C for that decision. A request that drops at the same edge it would have won is not granted.
- A preempted requester that still requests re-enters arbitration normally. In MODE=1 it is last in line; in MODE=0 it wins again at the next decision if it has the lowest index.
- Width rules: hold_cnt is $clog2(MAX_HOLD+1) bits. The rr pointer is IDW bits, and wrap is mod N (correct for non-power-of-2 N).

Test Plan:
1. N=4, MODE=1, MAX_HOLD=4; reset=1 for 3 cycles with request=1111 -> grant=0000, grant_valid=0 throughout. The first edge after reset drops gives grant=0001 one cycle later.
2. Same config, request held at 1111 -> grant sequence 0001×4, 0010×4, 0100×4, 1000×4, then wraps to 0001. Never a zero cycle, always one-hot.
3. request=0101, requester 0 drops after 2 granted cycles -> grant 0001,0001, then 0100 on the next edge with no gap. grant_id 0 then 2.
4. Only request=0010 for 10 cycles -> grant=0010 for all 10 cycles (no preemption, counter saturates). Then request=0000 -> grant=0000 and grant_valid=0 next edge, grant_id stays 1.
5. MODE=0, MAX_HOLD=2: request=0100 alone, then request=1101 -> requester 2 is held 2 cycles, then preempted to 0001. Requester 0 keeps the grant for 2 cycles, then goes to 0100 (index 2 beats index 3).
6. Mid-grant reset: owner 0010 in BUSY, hold_cnt=2, pulse reset for 1 cycle with request=1111 -> grant=0000 at that edge. Then grant=0001 (pointer back to N-1), hold_cnt restarts at 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// N-requester arbiter with fixed-priority or round-robin selection and bounded hold.
// Grant is registered one-hot; grant_id holds the last owner while idle.
module rr_arbiter #(
    parameter  int N        = 4,
    parameter  int MODE     = 1,
    parameter  int MAX_HOLD = 4,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [N-1:0]   ONE       = N'(1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   grant_n;
    logic [IDW-1:0] id_n;
    logic [HCW-1:0] hold_cnt, hold_n;
    logic [IDW-1:0] last, last_n;

    logic [N-1:0]   masked;
    logic           owner_req;
    logic           take;
    logic [N-1:0]   cand;
    logic [IDW-1:0] win;

    // MODE=0: lowest set index. MODE=1: first set bit after ptr, wrapping mod N.
    function automatic logic [IDW-1:0] pick_winner(input logic [N-1:0]   c,
                                                   input logic [IDW-1:0] ptr);
        logic [IDW-1:0] w;
        logic [IDW-1:0] idx;
        w = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (MODE == 0) ? IDW'(k - 1) : IDW'((int'(ptr) + k) % N);
            if (c[idx]) w = idx;
        end
        return w;
    endfunction

    assign masked      = request & ~(ONE << grant_id);
    assign owner_req   = request[grant_id];
    assign grant_valid = |grant;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n = state;
        grant_n = grant;
        id_n    = grant_id;
        hold_n  = hold_cnt;
        last_n  = last;
        take    = 1'b0;
        cand    = '0;
        win     = '0;

        unique case (state)
            IDLE: begin
                grant_n = '0;
                if (request != '0) begin
                    take = 1'b1;
                    cand = request;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (masked != '0) begin
                        take = 1'b1;
                        cand = masked;
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (masked != '0)) begin
                    take = 1'b1;
                    cand = masked;
                end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
                    hold_n = hold_cnt + HCW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // A handover replaces the owner in one step, so the grant never doubles or gaps.
        if (take) begin
            win     = pick_winner(cand, last);
            grant_n = ONE << win;
            id_n    = win;
            hold_n  = '0;
            last_n  = win;
            state_n = BUSY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            last     <= LAST_INIT;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= id_n;
            hold_cnt <= hold_n;
            last     <= last_n;
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule
